fp_unit_issue_ctrl: RTL

- Initiator-side controller that drives one shared APU FP unit (sqrt/div/add class) through its En/OpA/Tag/Rnd request port.
- Collects Valid/Tag/Res/Status results and returns them to the requester in issue order.
- Owns tag allocation: a circular pool of 2**TAG_WIDTH slots, each tag equal to its slot index.
- Sits between the core-side request arbiter and an FP unit wrapper with 0..N post pipe registers.

---
 rtl/fp_unit_issue_ctrl_pkg.sv | 34 +++
 rtl/fp_unit_issue_ctrl_if.sv | 53 +++++
 rtl/fp_unit_issue_ctrl_slot_pool.sv | 101 ++++++++++
 rtl/fp_unit_issue_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fp_unit_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apu_cluster_package
// Description : Shared types and default widths for the FP unit issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package apu_cluster_package;

  localparam int FP_WIDTH_DEF       = 32;
  localparam int TAG_WIDTH_DEF      = 2;
  localparam int RND_WIDTH_DEF      = 3;
  localparam int STAT_WIDTH_DEF     = 8;
  localparam int ID_WIDTH_DEF       = 4;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ISSUED = 2'd1,
    DONE   = 2'd2
  } slot_state_t;

  typedef struct packed {
    slot_state_t                state;
    logic [ID_WIDTH_DEF-1:0]    id;
    logic [FP_WIDTH_DEF-1:0]    res;
    logic [STAT_WIDTH_DEF-1:0]  status;
  } slot_t;

  function automatic int num_slots(input int tag_width);
    return 1 << tag_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_unit_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_unit_issue_ctrl_if
// Description : Requester, FP-unit and response signals of the issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_unit_issue_ctrl_if #(
  parameter int FP_WIDTH   = 32,
  parameter int TAG_WIDTH  = 2,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 8,
  parameter int ID_WIDTH   = 4
);
  logic                  ReqValid_i;
  logic                  ReqReady_o;
  logic [FP_WIDTH-1:0]   ReqOpA_i;
  logic [RND_WIDTH-1:0]  ReqRnd_i;
  logic [ID_WIDTH-1:0]   ReqId_i;
  logic                  En_o;
  logic [FP_WIDTH-1:0]   OpA_o;
  logic [RND_WIDTH-1:0]  Rnd_o;
  logic [TAG_WIDTH-1:0]  Tag_o;
  logic                  UnitReady_i;
  logic                  UnitValid_i;
  logic [TAG_WIDTH-1:0]  UnitTag_i;
  logic [FP_WIDTH-1:0]   UnitRes_i;
  logic [STAT_WIDTH-1:0] UnitStatus_i;
  logic                  RespValid_o;
  logic                  RespReady_i;
  logic [FP_WIDTH-1:0]   RespRes_o;
  logic [STAT_WIDTH-1:0] RespStatus_o;
  logic [ID_WIDTH-1:0]   RespId_o;
  logic [TAG_WIDTH:0]    Outstanding_o;
  logic                  Err_o;

  // The controller is the slave of its requester and of the result stream.
  modport slave (
    input  ReqValid_i, ReqOpA_i, ReqRnd_i, ReqId_i,
    input  UnitReady_i, UnitValid_i, UnitTag_i, UnitRes_i, UnitStatus_i,
    input  RespReady_i,
    output ReqReady_o, En_o, OpA_o, Rnd_o, Tag_o,
    output RespValid_o, RespRes_o, RespStatus_o, RespId_o, Outstanding_o, Err_o
  );

  modport master (
    output ReqValid_i, ReqOpA_i, ReqRnd_i, ReqId_i,
    output UnitReady_i, UnitValid_i, UnitTag_i, UnitRes_i, UnitStatus_i,
    output RespReady_i,
    input  ReqReady_o, En_o, OpA_o, Rnd_o, Tag_o,
    input  RespValid_o, RespRes_o, RespStatus_o, RespId_o, Outstanding_o, Err_o
  );
endinterface
`default_nettype wire

// File: rtl/fp_unit_issue_ctrl_slot_pool.sv
`default_nettype none
// ============================================================================
// Module      : fp_issue_slot_pool
// Description : Tag-indexed slot array (FREE/ISSUED/DONE) with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_issue_slot_pool
  import apu_cluster_package::*;
#(
  parameter int FP_WIDTH   = FP_WIDTH_DEF,
  parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int STAT_WIDTH = STAT_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_i,
  input  wire logic [TAG_WIDTH-1:0]  wr_idx,
  output logic                       wr_free,
  input  wire logic                  alloc_en,
  input  wire logic [ID_WIDTH-1:0]   alloc_id,
  input  wire logic                  cap_en,
  input  wire logic [TAG_WIDTH-1:0]  cap_idx,
  input  wire logic [FP_WIDTH-1:0]   cap_res,
  input  wire logic [STAT_WIDTH-1:0] cap_status,
  input  wire logic [TAG_WIDTH-1:0]  rd_idx,
  input  wire logic                  retire_en,
  input  wire logic                  force_en,
  output slot_state_t                rd_state,
  output logic [ID_WIDTH-1:0]        rd_id,
  output logic [FP_WIDTH-1:0]        rd_res,
  output logic [STAT_WIDTH-1:0]      rd_status,
  output logic [TAG_WIDTH:0]         outstanding,
  output logic                       err
);
  localparam int NUM_SLOTS = num_slots(TAG_WIDTH);
  localparam logic [TAG_WIDTH:0] C_CNT_ONE = 1;

  slot_state_t             r_state  [NUM_SLOTS];
  logic [ID_WIDTH-1:0]     r_id     [NUM_SLOTS];
  logic [FP_WIDTH-1:0]     r_res    [NUM_SLOTS];
  logic [STAT_WIDTH-1:0]   r_status [NUM_SLOTS];
  logic                    r_err;
  logic                    w_cap_hit;
  logic [TAG_WIDTH:0]      w_cnt;

  assign w_cap_hit = cap_en && (r_state[cap_idx] == ISSUED);

  // Alloc, capture and retire target disjoint states, so one slot sees at most one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i]  <= FREE;
        r_id[i]     <= '0;
        r_res[i]    <= '0;
        r_status[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (alloc_en && (wr_idx == TAG_WIDTH'(i))) begin
          r_state[i] <= ISSUED;
          r_id[i]    <= alloc_id;
        end
        if (w_cap_hit && (cap_idx == TAG_WIDTH'(i))) begin
          r_state[i]  <= DONE;
          r_res[i]    <= cap_res;
          r_status[i] <= cap_status;
        end else if (force_en && (rd_idx == TAG_WIDTH'(i))) begin
          r_state[i]  <= DONE;
          r_res[i]    <= '0;
          r_status[i] <= '1;
        end
        if (retire_en && (rd_idx == TAG_WIDTH'(i))) begin
          r_state[i] <= FREE;
        end
      end
      if (cap_en && !w_cap_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_state[i] != FREE) begin
        w_cnt = w_cnt + C_CNT_ONE;
      end
    end
  end

  assign wr_free     = (r_state[wr_idx] == FREE);
  assign rd_state    = r_state[rd_idx];
  assign rd_id       = r_id[rd_idx];
  assign rd_res      = r_res[rd_idx];
  assign rd_status   = r_status[rd_idx];
  assign outstanding = w_cnt;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: rtl/fp_unit_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fp_unit_issue_ctrl
// Description : Tagged in-order issue/retire controller for a shared FP unit.
//               Optional result watchdog enabled by macro FP_ISSUE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_unit_issue_ctrl
  import apu_cluster_package::*;
#(
  parameter int FP_WIDTH       = FP_WIDTH_DEF,
  parameter int TAG_WIDTH      = TAG_WIDTH_DEF,
  parameter int RND_WIDTH      = RND_WIDTH_DEF,
  parameter int STAT_WIDTH     = STAT_WIDTH_DEF,
  parameter int ID_WIDTH       = ID_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input wire logic            clk_i,
  input wire logic            rst_i,
  fp_unit_issue_ctrl_if.slave bus
);
  localparam logic [TAG_WIDTH-1:0] C_PTR_ONE = 1;

  logic [TAG_WIDTH-1:0]  r_wr_ptr;
  logic [TAG_WIDTH-1:0]  r_rd_ptr;
  logic                  r_en;
  logic [FP_WIDTH-1:0]   r_opa;
  logic [RND_WIDTH-1:0]  r_rnd;
  logic [TAG_WIDTH-1:0]  r_tag;

  logic                  w_wr_free;
  logic                  w_accept;
  logic                  w_retire;
  logic                  w_force;
  slot_state_t           w_rd_state;
  logic [ID_WIDTH-1:0]   w_rd_id;
  logic [FP_WIDTH-1:0]   w_rd_res;
  logic [STAT_WIDTH-1:0] w_rd_status;
  logic [TAG_WIDTH:0]    w_outstanding;
  logic                  w_err;

  assign bus.ReqReady_o = w_wr_free && (!r_en || bus.UnitReady_i);
  assign w_accept       = bus.ReqValid_i && bus.ReqReady_o;
  assign w_retire       = (w_rd_state == DONE) && bus.RespReady_i;

  // Unit request register: a new accept can only land when the previous one transfers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_en     <= 1'b0;
      r_opa    <= '0;
      r_rnd    <= '0;
      r_tag    <= '0;
    end else begin
      if (w_accept) begin
        r_en     <= 1'b1;
        r_opa    <= bus.ReqOpA_i;
        r_rnd    <= bus.ReqRnd_i;
        r_tag    <= r_wr_ptr;
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end else if (bus.UnitReady_i) begin
        r_en <= 1'b0;
      end
      if (w_retire) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
    end
  end

`ifdef FP_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_WD_ONE   = 1;

  logic [CNT_W-1:0] r_wd_cnt;

  // rd_ptr only moves on retire, which leaves the head non-ISSUED, so this also restarts on pointer change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd_cnt <= '0;
    end else if ((w_rd_state != ISSUED) || w_force) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + C_WD_ONE;
    end
  end

  assign w_force = (w_rd_state == ISSUED) && (r_wd_cnt == C_WD_LIMIT);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_force          = 1'b0;
`endif

  fp_issue_slot_pool #(
    .FP_WIDTH   (FP_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .STAT_WIDTH (STAT_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_pool (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_idx      (r_wr_ptr),
    .wr_free     (w_wr_free),
    .alloc_en    (w_accept),
    .alloc_id    (bus.ReqId_i),
    .cap_en      (bus.UnitValid_i),
    .cap_idx     (bus.UnitTag_i),
    .cap_res     (bus.UnitRes_i),
    .cap_status  (bus.UnitStatus_i),
    .rd_idx      (r_rd_ptr),
    .retire_en   (w_retire),
    .force_en    (w_force),
    .rd_state    (w_rd_state),
    .rd_id       (w_rd_id),
    .rd_res      (w_rd_res),
    .rd_status   (w_rd_status),
    .outstanding (w_outstanding),
    .err         (w_err)
  );

  assign bus.En_o          = r_en;
  assign bus.OpA_o         = r_opa;
  assign bus.Rnd_o         = r_rnd;
  assign bus.Tag_o         = r_tag;
  assign bus.RespValid_o   = (w_rd_state == DONE);
  assign bus.RespRes_o     = w_rd_res;
  assign bus.RespStatus_o  = w_rd_status;
  assign bus.RespId_o      = w_rd_id;
  assign bus.Outstanding_o = w_outstanding;
  assign bus.Err_o         = w_err;

endmodule
`default_nettype wire
